nexi_bus_arbiter: RTL and testbench

- Shares one Wishbone master port on the system bus between NUM_MASTERS requesters, typically nexi_cache_controller bus-side master ports.
- Uses round-robin arbitration, registered grants and whole-cycle (cyc) tenure.
- Runs a bus watchdog that terminates stalled strobes with an error.
- Sits between the cache controllers and the system interconnect. Sniffers snoop the arbiter's bus-side outputs.

---
 rtl/nexi_bus_pkg.sv | 40 ++++
 rtl/nexi_rr_picker.sv | 32 +++
 rtl/nexi_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_nexi_bus_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nexi_bus_pkg.sv
`timescale 1ns/1ps
// nexi_bus_pkg
// Shared definitions for the NEXI bus arbiter slice.
//   arb_state_t  : arbiter FSM encoding (IDLE / OWNED)
//   MAX_MASTERS  : upper bound on requesters supported by the priority search
//   rr_search()  : round-robin priority search, returns a one-hot winner
package nexi_bus_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    localparam int MAX_MASTERS = 8;

    // Scan from last+1 upward with wrap-around over the first 'num' requesters.
    // The first set request bit wins. With no request set, the result is zero.
    function automatic logic [MAX_MASTERS-1:0] rr_search(
        input logic [MAX_MASTERS-1:0] req,
        input int unsigned            num,
        input logic [2:0]             last
    );
        logic [MAX_MASTERS-1:0] hit;
        logic                   found;
        int unsigned            idx;
        hit   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_MASTERS; i++) begin
            if (i <= num) begin
                idx = (int'(last) + i) % num;
                if (!found && req[idx[2:0]]) begin
                    hit[idx[2:0]] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/nexi_rr_picker.sv
`timescale 1ns/1ps
// nexi_rr_picker
// Combinational one-hot round-robin picker.
//   req   in  N      request vector
//   last  in  IDX_W  index of the most recently granted requester
//   grant out N      one-hot winner (all zero when req is zero)
module nexi_rr_picker
    import nexi_bus_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant
);

    logic [MAX_MASTERS-1:0] req_pad;
    logic [MAX_MASTERS-1:0] pick;
    logic [2:0]             last_pad;

    // Widen to the fixed search width so one function serves every N.
    always_comb begin
        req_pad              = '0;
        req_pad[N-1:0]       = req;
        last_pad             = '0;
        last_pad[IDX_W-1:0]  = last;
        pick                 = rr_search(req_pad, N, last_pad);
        grant                = pick[N-1:0];
    end

endmodule

// File: rtl/nexi_bus_arbiter.sv
`timescale 1ns/1ps
// nexi_bus_arbiter
// Shares one Wishbone master port between NUM_MASTERS requesters using
// round-robin arbitration, registered grants and whole-cycle (cyc) tenure.
// A watchdog terminates stalled strobes with an error to the owner.
//   clk_i, reset_i          clock, asynchronous active-high reset
//   m_addr_i/m_data_i       packed per-master address / write data
//   m_cyc/sel/stb/we_i      per-master control
//   m_data_o                bus read data broadcast to all masters
//   m_ack/err/rty_o         responses routed to the owner only
//   bus_*_o                 owner's request, zero when nobody is granted
//   bus_data/ack/err/rty_i  system bus responses
//   grant_o                 registered one-hot grant
//   busy_o                  high while a master owns the bus
module nexi_bus_arbiter
    import nexi_bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_i,
    output logic [DATA_WIDTH-1:0]             m_data_o,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_sel_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [NUM_MASTERS-1:0]            m_rty_o,
    output logic [ADDR_WIDTH-1:0]             bus_addr_o,
    output logic [DATA_WIDTH-1:0]             bus_data_o,
    output logic                              bus_cyc_o,
    output logic                              bus_sel_o,
    output logic                              bus_stb_o,
    output logic                              bus_we_o,
    input  logic [DATA_WIDTH-1:0]             bus_data_i,
    input  logic                              bus_ack_i,
    input  logic                              bus_err_i,
    input  logic                              bus_rty_i,
    output logic [NUM_MASTERS-1:0]            grant_o,
    output logic                              busy_o
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_MASTERS - 1);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [NUM_MASTERS-1:0] pick;
    logic                   owner_cyc;
    logic                   wd_fire;
    logic                   stb_raw;

    nexi_rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (m_cyc_i),
        .last  (last_q),
        .grant (pick)
    );

    assign owner_cyc = |(m_cyc_i & grant_q);

    // State, grant and round-robin pointer registers. Grant is reset
    // asynchronously so the bus-side outputs drop the moment reset rises.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RESET;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic. A released tenure always passes through IDLE for
    // one cycle, which gives the single idle bus cycle between owners.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (|m_cyc_i) begin
                    state_d = OWNED;
                    grant_d = pick;
                    for (int k = 0; k < NUM_MASTERS; k++) begin
                        if (pick[k]) begin
                            last_d = IDX_W'(k);
                        end
                    end
                end
            end
            OWNED: begin
                if (!owner_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output logic: owner mux onto the bus, responses back to the owner.
    // The watchdog suppresses stb during the cycle it injects its error.
    always_comb begin
        busy_o     = (state_q == OWNED);
        bus_addr_o = '0;
        bus_data_o = '0;
        bus_cyc_o  = 1'b0;
        bus_sel_o  = 1'b0;
        stb_raw    = 1'b0;
        bus_we_o   = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_q[k]) begin
                bus_addr_o = m_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                bus_data_o = m_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                bus_cyc_o  = m_cyc_i[k];
                bus_sel_o  = m_sel_i[k];
                stb_raw    = m_stb_i[k];
                bus_we_o   = m_we_i[k];
            end
        end
        bus_stb_o = stb_raw & ~wd_fire;
        m_data_o  = bus_data_i;
        m_ack_o   = grant_q & {NUM_MASTERS{bus_ack_i}};
        m_err_o   = grant_q & {NUM_MASTERS{bus_err_i | wd_fire}};
        m_rty_o   = grant_q & {NUM_MASTERS{bus_rty_i}};
    end

    generate
        if (TIMEOUT > 0) begin : g_watchdog
            localparam int WD_W = $clog2(TIMEOUT + 1);
            localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
            logic [WD_W-1:0] wd_count;

            // Counts consecutive unanswered strobe cycles. A response in the
            // cycle that would reach the limit clears it, so no error fires.
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    wd_count <= '0;
                end else if (bus_stb_o && !(bus_ack_i || bus_err_i || bus_rty_i)) begin
                    wd_count <= wd_count + 1'b1;
                end else begin
                    wd_count <= '0;
                end
            end

            assign wd_fire = (wd_count == WD_LIMIT) && (|grant_q);
        end else begin : g_no_watchdog
            assign wd_fire = 1'b0;
        end
    endgenerate

    assign grant_o = grant_q;

endmodule

// File: tb/tb_nexi_bus_arbiter.sv
`timescale 1ns/1ps
// tb_nexi_bus_arbiter
// Directed self-checking bench for nexi_bus_arbiter (2 masters, TIMEOUT=4).
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_nexi_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NM = 2;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [NM*AW-1:0] m_addr_i;
    logic [NM*DW-1:0] m_data_i;
    logic [DW-1:0]   m_data_o;
    logic [NM-1:0]   m_cyc_i, m_sel_i, m_stb_i, m_we_i;
    logic [NM-1:0]   m_ack_o, m_err_o, m_rty_o;
    logic [AW-1:0]   bus_addr_o;
    logic [DW-1:0]   bus_data_o;
    logic            bus_cyc_o, bus_sel_o, bus_stb_o, bus_we_o;
    logic [DW-1:0]   bus_data_i;
    logic            bus_ack_i, bus_err_i, bus_rty_i;
    logic [NM-1:0]   grant_o;
    logic            busy_o;

    int checks = 0;
    int errors = 0;

    nexi_bus_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .NUM_MASTERS (NM),
        .TIMEOUT     (4)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .m_addr_i   (m_addr_i),
        .m_data_i   (m_data_i),
        .m_data_o   (m_data_o),
        .m_cyc_i    (m_cyc_i),
        .m_sel_i    (m_sel_i),
        .m_stb_i    (m_stb_i),
        .m_we_i     (m_we_i),
        .m_ack_o    (m_ack_o),
        .m_err_o    (m_err_o),
        .m_rty_o    (m_rty_o),
        .bus_addr_o (bus_addr_o),
        .bus_data_o (bus_data_o),
        .bus_cyc_o  (bus_cyc_o),
        .bus_sel_o  (bus_sel_o),
        .bus_stb_o  (bus_stb_o),
        .bus_we_o   (bus_we_o),
        .bus_data_i (bus_data_i),
        .bus_ack_i  (bus_ack_i),
        .bus_err_i  (bus_err_i),
        .bus_rty_i  (bus_rty_i),
        .grant_o    (grant_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        m_addr_i   = '0;
        m_data_i   = '0;
        m_cyc_i    = '0;
        m_sel_i    = '0;
        m_stb_i    = '0;
        m_we_i     = '0;
        bus_data_i = '0;
        bus_ack_i  = 1'b0;
        bus_err_i  = 1'b0;
        bus_rty_i  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_i  = 1'b1;
        m_cyc_i  = 2'b11;
        m_stb_i  = 2'b11;
        m_we_i   = 2'b11;
        m_sel_i  = 2'b11;
        m_addr_i = {32'hDEAD0000, 32'h0000BEEF};
        bus_ack_i = 1'b1;
        bus_err_i = 1'b1;
        bus_rty_i = 1'b1;
        tick();
        tick();
        checks++;
        if ({grant_o, busy_o} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_grant_busy: got %b expected 000", {grant_o, busy_o});
        end
        checks++;
        if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_bus_ctl: got %b expected 0000", {bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o});
        end
        checks++;
        if (bus_addr_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_bus_addr: got %h expected 00000000", bus_addr_o);
        end
        checks++;
        if ({m_ack_o, m_err_o, m_rty_o} !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL reset_responses: got %b expected 000000", {m_ack_o, m_err_o, m_rty_o});
        end
        clear_inputs();
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_single_request();
        do_reset();
        m_cyc_i[0] = 1'b1;
        m_stb_i[0] = 1'b1;
        m_we_i[0]  = 1'b1;
        m_sel_i[0] = 1'b1;
        m_addr_i[0 +: AW] = 32'h00000100;
        m_data_i[0 +: DW] = 32'hA5A5A5A5;
        #1;
        checks++;
        if (bus_cyc_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_latency: bus_cyc got %b expected 0", bus_cyc_o);
        end
        tick();
        checks++;
        if ({grant_o, busy_o, bus_cyc_o, bus_stb_o, bus_we_o} !== 6'b011111) begin
            errors++;
            $display("[TB] FAIL single_grant: got %b expected 011111", {grant_o, busy_o, bus_cyc_o, bus_stb_o, bus_we_o});
        end
        checks++;
        if (bus_addr_o !== 32'h00000100 || bus_data_o !== 32'hA5A5A5A5) begin
            errors++;
            $display("[TB] FAIL single_datapath: got %h/%h expected 00000100/a5a5a5a5", bus_addr_o, bus_data_o);
        end
        bus_ack_i = 1'b1;
        #1;
        checks++;
        if (m_ack_o !== 2'b01) begin
            errors++;
            $display("[TB] FAIL single_ack: got %b expected 01", m_ack_o);
        end
        tick();
        bus_ack_i  = 1'b0;
        m_cyc_i[0] = 1'b0;
        m_stb_i[0] = 1'b0;
        tick();
        checks++;
        if ({grant_o, busy_o, bus_cyc_o} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL single_release: got %b expected 0000", {grant_o, busy_o, bus_cyc_o});
        end
    endtask

    task automatic test_fairness();
        logic [NM-1:0] exp_grant;
        int            owner;
        do_reset();
        m_cyc_i = 2'b11;
        m_stb_i = 2'b11;
        m_addr_i = {32'h00000200, 32'h00000100};
        tick();
        for (int e = 0; e < 4; e++) begin
            owner     = e % 2;
            exp_grant = (owner == 0) ? 2'b01 : 2'b10;
            checks++;
            if (grant_o !== exp_grant) begin
                errors++;
                $display("[TB] FAIL fair_grant_%0d: got %b expected %b", e, grant_o, exp_grant);
            end
            for (int a = 0; a < 3; a++) begin
                bus_ack_i = 1'b1;
                if (a == 2) begin
                    m_cyc_i[owner] = 1'b0;
                    m_stb_i[owner] = 1'b0;
                end
                #1;
                checks++;
                if (m_ack_o !== exp_grant) begin
                    errors++;
                    $display("[TB] FAIL fair_ack_%0d_%0d: got %b expected %b", e, a, m_ack_o, exp_grant);
                end
                tick();
            end
            bus_ack_i = 1'b0;
            checks++;
            if ({grant_o, bus_cyc_o} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL fair_idle_%0d: got %b expected 000", e, {grant_o, bus_cyc_o});
            end
            if (e == 3) begin
                m_cyc_i = 2'b00;
                m_stb_i = 2'b00;
            end else begin
                m_cyc_i[owner] = 1'b1;
                m_stb_i[owner] = 1'b1;
            end
            tick();
        end
        checks++;
        if (grant_o !== 2'b00) begin
            errors++;
            $display("[TB] FAIL fair_end: got %b expected 00", grant_o);
        end
    endtask

    task automatic test_no_preemption();
        do_reset();
        m_cyc_i[1] = 1'b1;
        tick();
        checks++;
        if (grant_o !== 2'b10) begin
            errors++;
            $display("[TB] FAIL nopre_first: got %b expected 10", grant_o);
        end
        m_cyc_i[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (grant_o !== 2'b10 || busy_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL nopre_hold_%0d: got %b/%b expected 10/1", i, grant_o, busy_o);
            end
        end
        m_cyc_i[1] = 1'b0;
        tick();
        checks++;
        if (grant_o !== 2'b00) begin
            errors++;
            $display("[TB] FAIL nopre_gap: got %b expected 00", grant_o);
        end
        tick();
        checks++;
        if (grant_o !== 2'b01) begin
            errors++;
            $display("[TB] FAIL nopre_handover: got %b expected 01", grant_o);
        end
        m_cyc_i = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_response_isolation();
        do_reset();
        m_cyc_i[0] = 1'b1;
        tick();
        bus_err_i  = 1'b1;
        bus_data_i = 32'h12345678;
        #1;
        checks++;
        if ({m_err_o, m_ack_o, m_rty_o} !== 6'b010000) begin
            errors++;
            $display("[TB] FAIL iso_err: got %b expected 010000", {m_err_o, m_ack_o, m_rty_o});
        end
        checks++;
        if (m_data_o !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL iso_rdata: got %h expected 12345678", m_data_o);
        end
        tick();
        bus_err_i = 1'b0;
        bus_rty_i = 1'b1;
        #1;
        checks++;
        if ({m_rty_o, m_err_o, m_ack_o} !== 6'b010000) begin
            errors++;
            $display("[TB] FAIL iso_rty: got %b expected 010000", {m_rty_o, m_err_o, m_ack_o});
        end
        tick();
        bus_rty_i  = 1'b0;
        m_cyc_i[0] = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        m_cyc_i[0] = 1'b1;
        m_stb_i[0] = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus_stb_o !== 1'b1 || m_err_o !== 2'b00) begin
                errors++;
                $display("[TB] FAIL wd_stall_%0d: stb/err got %b/%b expected 1/00", i, bus_stb_o, m_err_o);
            end
            tick();
        end
        checks++;
        if (m_err_o !== 2'b01 || bus_stb_o !== 1'b0 || grant_o !== 2'b01) begin
            errors++;
            $display("[TB] FAIL wd_fire: err/stb/grant got %b/%b/%b expected 01/0/01", m_err_o, bus_stb_o, grant_o);
        end
        tick();
        checks++;
        if (m_err_o !== 2'b00 || bus_stb_o !== 1'b1 || grant_o !== 2'b01) begin
            errors++;
            $display("[TB] FAIL wd_after: err/stb/grant got %b/%b/%b expected 00/1/01", m_err_o, bus_stb_o, grant_o);
        end
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        tick();
        tick();

        do_reset();
        m_cyc_i[0] = 1'b1;
        m_stb_i[0] = 1'b1;
        tick();
        tick();
        tick();
        tick();
        bus_ack_i = 1'b1;
        #1;
        checks++;
        if (m_ack_o !== 2'b01 || m_err_o !== 2'b00) begin
            errors++;
            $display("[TB] FAIL wd_ack_race: ack/err got %b/%b expected 01/00", m_ack_o, m_err_o);
        end
        tick();
        bus_ack_i = 1'b0;
        #1;
        checks++;
        if (m_err_o !== 2'b00 || bus_stb_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wd_no_err: err/stb got %b/%b expected 00/1", m_err_o, bus_stb_o);
        end
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_tenure();
        do_reset();
        m_cyc_i[1] = 1'b1;
        m_stb_i[1] = 1'b1;
        tick();
        checks++;
        if (bus_cyc_o !== 1'b1 || grant_o !== 2'b10) begin
            errors++;
            $display("[TB] FAIL mid_owned: cyc/grant got %b/%b expected 1/10", bus_cyc_o, grant_o);
        end
        #2;
        reset_i = 1'b1;
        #1;
        checks++;
        if ({bus_cyc_o, bus_stb_o, grant_o, busy_o} !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL mid_async_drop: got %b expected 00000", {bus_cyc_o, bus_stb_o, grant_o, busy_o});
        end
        m_cyc_i = 2'b11;
        m_stb_i = 2'b00;
        tick();
        reset_i = 1'b0;
        tick();
        checks++;
        if (grant_o !== 2'b01) begin
            errors++;
            $display("[TB] FAIL mid_pointer_reset: got %b expected 01", grant_o);
        end
        m_cyc_i = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        reset_i = 1'b1;
        clear_inputs();
        test_reset();
        test_single_request();
        test_fairness();
        test_no_preemption();
        test_response_isolation();
        test_watchdog();
        test_reset_mid_tenure();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
